// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int aw, input int sets, input int words);
        return aw - $clog2(sets) - $clog2(words) - 2;
    endfunction

    // Keeps vector widths legal when a derived width collapses to zero.
    function automatic int nz(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays with combinational lookup and
// a synchronous word write that can also commit the line tag and valid bit.
module icache_way
    import icache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WORDS = 4,
    parameter int TAG_W = 22,
    parameter int IDX_W = 6,
    parameter int OFF_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              hit,
    output logic [WORD_W-1:0] word,
    output logic              valid,
    input  logic              wr_word,
    input  logic              wr_line,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_valid
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS][WORDS];

    assign valid = valid_q[rd_idx];
    assign hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign word  = data_q[rd_idx][rd_off];

    // A line commit after a clear still wins, so the caller folds any
    // same-cycle flush into wr_valid.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
        end else if (rdy_in) begin
            if (clear)
                valid_q <= '0;
            if (wr_line)
                valid_q[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in) begin
            if (wr_word)
                data_q[wr_idx][wr_off] <= wr_data;
            if (wr_line)
                tag_q[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hit path, word-by-word
// line refill from the RAM controller, round-robin replacement, flush.
//
//   state  | meaning
//   IDLE   | lookup; a miss latches the line and picks a victim way
//   REFILL | requesting words cnt=0..WORDS_PER_LINE-1 of the latched line
module icache_sa
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic [ADDR_WIDTH-1:0] if_icache_inst_addr_in,
    output logic                  icache_if_miss_out,
    output logic [WORD_W-1:0]     icache_if_inst_inst_out,
    output logic                  icache_ramctrl_en_out,
    output logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_out,
    input  logic                  ramctrl_icache_inst_rdy_in,
    input  logic [WORD_W-1:0]     ramctrl_icache_inst_inst_in
);

    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int OFF_WC = nz(OFF_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, SETS, WORDS_PER_LINE);
    localparam int WAY_W  = nz($clog2(WAYS));
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << (OFF_W + 2)) - ADDR_WIDTH'(1));

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_WC-1:0] off;

    assign tag = TAG_W'(if_icache_inst_addr_in >> (IDX_W + OFF_W + 2));
    assign idx = IDX_W'(if_icache_inst_addr_in >> (OFF_W + 2));
    assign off = OFF_WC'((if_icache_inst_addr_in >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));

    state_t            state;
    logic [TAG_W-1:0]  line_tag;
    logic [IDX_W-1:0]  line_idx;
    logic [OFF_WC-1:0] cnt;
    logic [WAY_W-1:0]  victim;
    logic              poison;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic [WAYS-1:0]   way_hit;
    logic [WAYS-1:0]   way_valid;
    logic [WORD_W-1:0] way_word [WAYS];

    logic              hit;
    logic [WORD_W-1:0] hit_word;
    logic [WAY_W-1:0]  victim_sel;
    logic [WAY_W-1:0]  rr_next;
    logic              last_word;
    logic              word_we;
    logic              line_valid;

    assign last_word  = (cnt == OFF_WC'(WORDS_PER_LINE - 1));
    assign word_we    = rdy_in && (state == REFILL) && ramctrl_icache_inst_rdy_in;
    assign line_valid = !poison && !flush_in;
    assign rr_next    = (WAYS > 1) ? rr_q[line_idx] + WAY_W'(1) : '0;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS  (SETS),
            .WORDS (WORDS_PER_LINE),
            .TAG_W (TAG_W),
            .IDX_W (IDX_W),
            .OFF_W (OFF_WC)
        ) u_way (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .rdy_in   (rdy_in),
            .clear    (flush_in),
            .rd_idx   (idx),
            .rd_tag   (tag),
            .rd_off   (off),
            .hit      (way_hit[w]),
            .word     (way_word[w]),
            .valid    (way_valid[w]),
            .wr_word  (word_we && (victim == WAY_W'(w))),
            .wr_line  (word_we && last_word && (victim == WAY_W'(w))),
            .wr_idx   (line_idx),
            .wr_off   (cnt),
            .wr_data  (ramctrl_icache_inst_inst_in),
            .wr_tag   (line_tag),
            .wr_valid (line_valid)
        );
    end

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit      = 1'b1;
                hit_word = way_word[w];
            end
        end
    end

    // Lowest invalid way first, otherwise the set's round-robin pointer.
    always_comb begin
        logic found;
        found      = 1'b0;
        victim_sel = rr_q[idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!way_valid[w] && !found) begin
                victim_sel = WAY_W'(w);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            line_tag <= '0;
            line_idx <= '0;
            cnt      <= '0;
            victim   <= '0;
            poison   <= 1'b0;
            for (int s = 0; s < SETS; s++)
                rr_q[s] <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (!flush_in && !hit) begin
                        line_tag <= tag;
                        line_idx <= idx;
                        cnt      <= '0;
                        victim   <= victim_sel;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush_in)
                        poison <= 1'b1;
                    if (ramctrl_icache_inst_rdy_in) begin
                        if (last_word) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            poison <= 1'b0;
                            if (victim == rr_q[line_idx])
                                rr_q[line_idx] <= rr_next;
                        end else begin
                            cnt <= cnt + OFF_WC'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [ADDR_WIDTH-1:0] line_base;
    assign line_base = (ADDR_WIDTH'({line_tag, line_idx}) << (OFF_W + 2))
                     | (ADDR_WIDTH'(cnt) << 2);

    assign icache_if_miss_out      = !rst_n_in || (state == REFILL) || !hit || flush_in;
    assign icache_if_inst_inst_out = icache_if_miss_out ? '0 : hit_word;
    assign icache_ramctrl_en_out   = rst_n_in && ((state == REFILL) || (!hit && !flush_in));
    assign icache_ramctrl_addr_out = (rst_n_in && (state == REFILL)) ? line_base
                                   : (if_icache_inst_addr_in & LINE_MASK);

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a fixed-latency RAM controller model.
module tb_icache_sa;

    localparam int LAT = 2;
    localparam int NV  = 24;

    logic        clk_in     = 1'b0;
    logic        rst_n_in   = 1'b0;
    logic        rdy_in     = 1'b0;
    logic        flush_in   = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        miss;
    logic [31:0] inst;
    logic        en;
    logic [31:0] raddr;
    logic        ram_rdy  = 1'b0;
    logic [31:0] ram_data = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] req_q [$];

    icache_sa dut (
        .clk_in                      (clk_in),
        .rst_n_in                    (rst_n_in),
        .rdy_in                      (rdy_in),
        .flush_in                    (flush_in),
        .if_icache_inst_addr_in      (fetch_addr),
        .icache_if_miss_out          (miss),
        .icache_if_inst_inst_out     (inst),
        .icache_ramctrl_en_out       (en),
        .icache_ramctrl_addr_out     (raddr),
        .ramctrl_icache_inst_rdy_in  (ram_rdy),
        .ramctrl_icache_inst_inst_in (ram_data)
    );

    initial forever #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // RAM controller: each requested word appears LAT cycles after its
    // address is first seen, and is held until the cache consumes it.
    initial begin
        logic        consumed;
        logic [31:0] cur_addr;
        int          lat_cnt;
        cur_addr = '0;
        lat_cnt  = 0;
        forever begin
            @(posedge clk_in);
            consumed = ram_rdy && rdy_in && rst_n_in;
            if (consumed)
                req_q.push_back(cur_addr);
            @(negedge clk_in);
            if (consumed) begin
                ram_rdy = 1'b0;
                lat_cnt = 0;
            end
            if (!rst_n_in || !en || raddr != cur_addr) begin
                ram_rdy  = 1'b0;
                lat_cnt  = 0;
                cur_addr = raddr;
            end
            if (rst_n_in && en && !ram_rdy && rdy_in) begin
                if (lat_cnt >= LAT - 1) begin
                    ram_rdy  = 1'b1;
                    ram_data = mem_word(cur_addr);
                end else begin
                    lat_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          phase;
        logic [31:0] addr;
        logic        miss;
    } vec_t;

    vec_t vecs [NV];

    task automatic samp();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic wait_hit(input string name, output int cycles);
        cycles = 0;
        forever begin
            samp();
            if (!miss) break;
            cycles++;
            if (cycles > 200) begin
                timeout(name);
                break;
            end
        end
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a, input logic need_rdy);
        int n;
        n = 0;
        forever begin
            samp();
            if (raddr == a && (!need_rdy || ram_rdy)) break;
            n++;
            if (n > 100) begin
                timeout(name);
                break;
            end
        end
    endtask

    task automatic check_reqs(input string name, input logic [31:0] base);
        check({name, "_count"}, 32'(req_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < req_q.size())
                check($sformatf("%s_%0d", name, i), req_q[i], base + 32'(4 * i));
    endtask

    task automatic fill(input string name, input logic [31:0] a);
        int cyc;
        req_q.delete();
        fetch_addr = a;
        rdy_in     = 1'b1;
        wait_hit(name, cyc);
        check({name, "_inst"}, inst, mem_word(a));
        check_reqs({name, "_req"}, a & 32'hFFFF_FFF0);
    endtask

    // Lookups are combinational, so rdy_in is held low to probe misses
    // without launching refills.
    task automatic apply_phase(input int p);
        rdy_in = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == p) begin
                fetch_addr = vecs[i].addr;
                samp();
                check_b($sformatf("p%0d_miss_%h", p, vecs[i].addr), miss, vecs[i].miss);
                check($sformatf("p%0d_inst_%h", p, vecs[i].addr), inst,
                      vecs[i].miss ? 32'h0 : mem_word(vecs[i].addr));
                check_b($sformatf("p%0d_en_%h", p, vecs[i].addr), en, vecs[i].miss);
            end
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{1, 32'h0000_0100, 1'b0};
        vecs[1]  = '{1, 32'h0000_0104, 1'b0};
        vecs[2]  = '{1, 32'h0000_0108, 1'b0};
        vecs[3]  = '{1, 32'h0000_010C, 1'b0};
        vecs[4]  = '{2, 32'h0000_0000, 1'b0};
        vecs[5]  = '{2, 32'h0000_040C, 1'b0};
        vecs[6]  = '{2, 32'h0000_0104, 1'b0};
        vecs[7]  = '{3, 32'h0000_0000, 1'b1};
        vecs[8]  = '{3, 32'h0000_0404, 1'b0};
        vecs[9]  = '{3, 32'h0000_0808, 1'b0};
        vecs[10] = '{4, 32'h0000_0400, 1'b1};
        vecs[11] = '{4, 32'h0000_0800, 1'b0};
        vecs[12] = '{4, 32'h0000_0C04, 1'b0};
        vecs[13] = '{5, 32'h0000_0100, 1'b1};
        vecs[14] = '{5, 32'h0000_0800, 1'b1};
        vecs[15] = '{5, 32'h0000_0C00, 1'b1};
        vecs[16] = '{6, 32'h0000_0200, 1'b1};
        vecs[17] = '{6, 32'h0000_0800, 1'b1};
        vecs[18] = '{7, 32'h0000_0300, 1'b0};
        vecs[19] = '{7, 32'h0000_0304, 1'b0};
        vecs[20] = '{7, 32'h0000_0308, 1'b0};
        vecs[21] = '{7, 32'h0000_030C, 1'b0};
        vecs[22] = '{8, 32'h0000_0300, 1'b1};
        vecs[23] = '{8, 32'h0000_0100, 1'b1};

        // Reset values
        rst_n_in   = 1'b0;
        rdy_in     = 1'b1;
        fetch_addr = 32'h0000_0107;
        repeat (3) samp();
        check_b("rst_miss", miss, 1'b1);
        check_b("rst_en", en, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_addr", raddr, 32'h0000_0100);

        // Cold miss on 0x104
        req_q.delete();
        rst_n_in   = 1'b1;
        fetch_addr = 32'h0000_0104;
        wait_hit("cold_fill", cyc);
        check("cold_latency", 32'(cyc), 32'(4 * LAT));
        check("cold_inst", inst, mem_word(32'h0000_0104));
        check_reqs("cold_req", 32'h0000_0100);
        apply_phase(1);

        // Conflict and round-robin replacement in set 0
        fill("fill_000", 32'h0000_0000);
        fill("fill_400", 32'h0000_0400);
        apply_phase(2);
        fill("fill_800", 32'h0000_0800);
        apply_phase(3);
        fill("fill_C00", 32'h0000_0C00);
        apply_phase(4);

        // Flush in IDLE while fetching a resident line
        rdy_in     = 1'b1;
        fetch_addr = 32'h0000_0100;
        flush_in   = 1'b1;
        #1;
        check_b("flush_idle_miss", miss, 1'b1);
        check_b("flush_idle_en", en, 1'b0);
        samp();
        flush_in = 1'b0;
        rdy_in   = 1'b0;
        apply_phase(5);
        fill("refill_800", 32'h0000_0800);

        // Flush during the third word of a refill of 0x200
        req_q.delete();
        fetch_addr = 32'h0000_0200;
        rdy_in     = 1'b1;
        wait_addr("poison_wait", 32'h0000_0208, 1'b0);
        flush_in = 1'b1;
        samp();
        flush_in = 1'b0;
        begin
            int n;
            n = 0;
            while (req_q.size() < 4) begin
                samp();
                n++;
                if (n > 100) begin
                    timeout("poison_done");
                    break;
                end
            end
        end
        rdy_in = 1'b0;
        check_reqs("poison_req", 32'h0000_0200);
        apply_phase(6);

        // Global enable low for 5 cycles with a RAM word pending
        req_q.delete();
        fetch_addr = 32'h0000_0300;
        rdy_in     = 1'b1;
        wait_addr("freeze_wait", 32'h0000_0304, 1'b1);
        rdy_in     = 1'b0;
        fetch_addr = 32'h0000_030C;
        for (int i = 0; i < 5; i++) begin
            samp();
            check($sformatf("freeze_addr_%0d", i), raddr, 32'h0000_0304);
            check_b($sformatf("freeze_miss_%0d", i), miss, 1'b1);
        end
        rdy_in = 1'b1;
        wait_hit("freeze_fill", cyc);
        check("freeze_inst", inst, mem_word(32'h0000_030C));
        check_reqs("freeze_req", 32'h0000_0300);
        apply_phase(7);

        // Reset in the middle of a refill
        req_q.delete();
        fetch_addr = 32'h0000_0100;
        rdy_in     = 1'b1;
        wait_addr("rstmid_wait", 32'h0000_0108, 1'b0);
        rst_n_in = 1'b0;
        #1;
        check_b("rstmid_en", en, 1'b0);
        check_b("rstmid_miss", miss, 1'b1);
        check("rstmid_inst", inst, 32'h0);
        check("rstmid_addr", raddr, 32'h0000_0100);
        samp();
        samp();
        rdy_in   = 1'b0;
        rst_n_in = 1'b1;
        apply_phase(8);
        req_q.delete();
        rdy_in = 1'b1;
        samp();
        check("rstmid_restart_addr", raddr, 32'h0000_0100);
        check_b("rstmid_restart_en", en, 1'b1);
        wait_hit("rstmid_fill", cyc);
        check("rstmid_fill_inst", inst, mem_word(32'h0000_0100));
        check_reqs("rstmid_req", 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
